// File: rtl/coef_bank_shadow.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : coef_bank_shadow
// Brief    : Double-buffered equalizer coefficient bank. Control writes go to a
//            shadow bank; dirty entries move atomically to the active bank on
//            the first sample tick after a commit request.
// Revision : 1.0 - initial release
// ============================================================================
module coef_bank_shadow #(
    parameter int               WIDTH     = 16,
    parameter int               CHANNELS  = 4,
    parameter int               AW        = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      commit_req,
    input  logic                      sample_tick,
    input  logic                      rd_sel,
    input  logic [AW-1:0]             rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic [CHANNELS*WIDTH-1:0] active_flat,
    output logic [CHANNELS-1:0]       dirty,
    output logic                      pending,
    output logic                      commit_done
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam logic [AW:0] c_channels = (AW+1)'(CHANNELS);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      shadow_q [CHANNELS];
    logic [WIDTH-1:0]      shadow_d [CHANNELS];
    logic [WIDTH-1:0]      active_q [CHANNELS];
    logic [WIDTH-1:0]      active_d [CHANNELS];
    logic [CHANNELS-1:0]   dirty_q, dirty_d;
    logic                  commit_done_q, commit_done_d;
    logic [WIDTH-1:0]      rd_data_q, rd_data_d;

    logic                  w_commit_edge;
    logic                  w_wr_hit;

    assign w_commit_edge = (state_q == ST_PENDING) && sample_tick;
    assign w_wr_hit      = wr_en && ({1'b0, wr_addr} < c_channels);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A tick in the arming cycle is too early; commit waits for the next one.
                if (commit_req && (|dirty_q)) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (sample_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The commit copies pre-edge shadow values, so a coincident write stays dirty.
    always_comb begin
        dirty_d       = w_commit_edge ? '0 : dirty_q;
        commit_done_d = w_commit_edge;
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = active_q[i];
            if (w_commit_edge && dirty_q[i]) begin
                active_d[i] = shadow_q[i];
            end
            if (w_wr_hit && (wr_addr == AW'(i))) begin
                shadow_d[i] = wr_data;
                dirty_d[i]  = 1'b1;
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_data_d = rd_sel ? active_q[i] : shadow_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            dirty_q       <= '0;
            commit_done_q <= 1'b0;
            rd_data_q     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= RESET_VAL;
                active_q[i] <= RESET_VAL;
            end
        end else begin
            state_q       <= state_d;
            dirty_q       <= dirty_d;
            commit_done_q <= commit_done_d;
            rd_data_q     <= rd_data_d;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_flat
            assign active_flat[g*WIDTH +: WIDTH] = active_q[g];
        end
    endgenerate

    assign rd_data     = rd_data_q;
    assign dirty       = dirty_q;
    assign pending     = (state_q == ST_PENDING);
    assign commit_done = commit_done_q;

endmodule
`default_nettype wire

// File: tb/tb_coef_bank_shadow.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_coef_bank_shadow
// Brief    : Table-driven bench for coef_bank_shadow plus reset-abort and
//            reduced-channel sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coef_bank_shadow;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en, commit_req, sample_tick, rd_sel;
    logic [1:0]  wr_addr, rd_addr;
    logic [15:0] wr_data, rd_data;
    logic [63:0] active_flat;
    logic [3:0]  dirty;
    logic        pending, commit_done;

    logic        w3_en, c3_req, t3_tick, r3_sel;
    logic [1:0]  w3_addr, r3_addr;
    logic [15:0] w3_data, r3_data;
    logic [47:0] a3_flat;
    logic [2:0]  d3_dirty;
    logic        p3_pending, c3_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    coef_bank_shadow #(.WIDTH(16), .CHANNELS(4), .AW(2), .RESET_VAL(16'h0000)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit_req(commit_req), .sample_tick(sample_tick), .rd_sel(rd_sel),
        .rd_addr(rd_addr), .rd_data(rd_data), .active_flat(active_flat),
        .dirty(dirty), .pending(pending), .commit_done(commit_done)
    );

    coef_bank_shadow #(.WIDTH(16), .CHANNELS(3), .AW(2), .RESET_VAL(16'h0000)) dut3 (
        .clk(clk), .reset(reset), .wr_en(w3_en), .wr_addr(w3_addr), .wr_data(w3_data),
        .commit_req(c3_req), .sample_tick(t3_tick), .rd_sel(r3_sel),
        .rd_addr(r3_addr), .rd_data(r3_data), .active_flat(a3_flat),
        .dirty(d3_dirty), .pending(p3_pending), .commit_done(c3_done)
    );

    typedef struct {
        logic        we;
        logic [1:0]  wa;
        logic [15:0] wd;
        logic        cr;
        logic        st;
        logic        rs;
        logic [1:0]  ra;
        logic [15:0] e_rd;
        logic [3:0]  e_dirty;
        logic        e_pend;
        logic        e_done;
        logic [63:0] e_act;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(logic we, logic [1:0] wa, logic [15:0] wd, logic cr,
                                logic st, logic rs, logic [1:0] ra, logic [15:0] e_rd,
                                logic [3:0] e_dirty, logic e_pend, logic e_done,
                                logic [63:0] e_act);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.cr = cr; v.st = st; v.rs = rs; v.ra = ra;
        v.e_rd = e_rd; v.e_dirty = e_dirty; v.e_pend = e_pend; v.e_done = e_done;
        v.e_act = e_act;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit_req = 1'b0;
        sample_tick = 1'b0; rd_sel = 1'b0; rd_addr = '0;
    endtask

    localparam logic [63:0] A1 = 64'hABCD_0000_1234_0000;
    localparam logic [63:0] A2 = 64'hABCD_0055_1234_0000;
    localparam logic [63:0] A3 = 64'hABCD_00AA_1234_0000;

    initial begin
        // Reset readback of every entry in both banks.
        for (int a = 0; a < 4; a++) begin
            for (int s = 0; s < 2; s++) begin
                tbl.push_back(mk(0, 2'(a), 16'h0, 0, 0, 1'(s), 2'(a), 16'h0, 4'b0000, 0, 0, 64'h0));
            end
        end
        // Write ch1/ch3, arm, wait five cycles, commit on tick.
        tbl.push_back(mk(1, 2'd1, 16'h1234, 0, 0, 0, 2'd1, 16'h0000, 4'b0010, 0, 0, 64'h0));
        tbl.push_back(mk(1, 2'd3, 16'hABCD, 0, 0, 0, 2'd1, 16'h1234, 4'b1010, 0, 0, 64'h0));
        tbl.push_back(mk(0, 2'd0, 16'h0000, 1, 0, 0, 2'd3, 16'hABCD, 4'b1010, 1, 0, 64'h0));
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(mk(0, 2'd0, 16'h0, 0, 0, 1, 2'd1, 16'h0000, 4'b1010, 1, 0, 64'h0));
        end
        tbl.push_back(mk(0, 2'd0, 16'h0, 0, 1, 1, 2'd1, 16'h0000, 4'b0000, 0, 1, A1));
        tbl.push_back(mk(0, 2'd0, 16'h0, 0, 0, 1, 2'd1, 16'h1234, 4'b0000, 0, 0, A1));
        tbl.push_back(mk(0, 2'd0, 16'h0, 0, 0, 1, 2'd3, 16'hABCD, 4'b0000, 0, 0, A1));
        // Commit request with nothing dirty is ignored, later tick has no effect.
        tbl.push_back(mk(0, 2'd0, 16'h0, 1, 0, 1, 2'd0, 16'h0000, 4'b0000, 0, 0, A1));
        tbl.push_back(mk(0, 2'd0, 16'h0, 0, 1, 0, 2'd1, 16'h1234, 4'b0000, 0, 0, A1));
        tbl.push_back(mk(0, 2'd0, 16'h0, 0, 0, 0, 2'd3, 16'hABCD, 4'b0000, 0, 0, A1));
        // ch2: arm together with a tick, then write during the commit edge.
        tbl.push_back(mk(1, 2'd2, 16'h0055, 0, 0, 0, 2'd2, 16'h0000, 4'b0100, 0, 0, A1));
        tbl.push_back(mk(0, 2'd0, 16'h0000, 1, 1, 0, 2'd2, 16'h0055, 4'b0100, 1, 0, A1));
        tbl.push_back(mk(1, 2'd2, 16'h00AA, 0, 1, 0, 2'd2, 16'h0055, 4'b0100, 0, 1, A2));
        tbl.push_back(mk(0, 2'd0, 16'h0000, 0, 0, 0, 2'd2, 16'h00AA, 4'b0100, 0, 0, A2));
        tbl.push_back(mk(0, 2'd0, 16'h0000, 0, 0, 1, 2'd2, 16'h0055, 4'b0100, 0, 0, A2));
        // Re-request while armed, then commit the leftover ch2 write.
        tbl.push_back(mk(0, 2'd0, 16'h0000, 1, 0, 1, 2'd2, 16'h0055, 4'b0100, 1, 0, A2));
        tbl.push_back(mk(0, 2'd0, 16'h0000, 1, 0, 0, 2'd2, 16'h00AA, 4'b0100, 1, 0, A2));
        tbl.push_back(mk(0, 2'd0, 16'h0000, 0, 1, 1, 2'd2, 16'h0055, 4'b0000, 0, 1, A3));
        tbl.push_back(mk(0, 2'd0, 16'h0000, 0, 0, 1, 2'd2, 16'h00AA, 4'b0000, 0, 0, A3));

        idle_inputs();
        w3_en = 1'b0; w3_addr = '0; w3_data = '0; c3_req = 1'b0; t3_tick = 1'b0;
        r3_sel = 1'b0; r3_addr = '0;
        reset = 1'b1;
        repeat (3) step();
        check("reset dirty", 64'(dirty), 64'h0);
        check("reset pending", 64'(pending), 64'h0);
        check("reset rd_data", 64'(rd_data), 64'h0);
        check("reset active_flat", active_flat, 64'h0);
        reset = 1'b0;
        step();

        for (int k = 0; k < tbl.size(); k++) begin
            wr_en = tbl[k].we; wr_addr = tbl[k].wa; wr_data = tbl[k].wd;
            commit_req = tbl[k].cr; sample_tick = tbl[k].st;
            rd_sel = tbl[k].rs; rd_addr = tbl[k].ra;
            step();
            check($sformatf("row%0d rd_data", k), 64'(rd_data), 64'(tbl[k].e_rd));
            check($sformatf("row%0d dirty", k), 64'(dirty), 64'(tbl[k].e_dirty));
            check($sformatf("row%0d pending", k), 64'(pending), 64'(tbl[k].e_pend));
            check($sformatf("row%0d commit_done", k), 64'(commit_done), 64'(tbl[k].e_done));
            check($sformatf("row%0d active_flat", k), active_flat, tbl[k].e_act);
        end
        idle_inputs();

        // Reset while a ch0 commit is armed aborts it.
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'h7777;
        step();
        wr_en = 1'b0; commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        check("abort armed", 64'(pending), 64'h1);
        check("abort dirty before", 64'(dirty), 64'h1);
        #2 reset = 1'b1;
        #1;
        check("abort pending", 64'(pending), 64'h0);
        check("abort dirty", 64'(dirty), 64'h0);
        check("abort active_flat", active_flat, 64'h0);
        step();
        reset = 1'b0;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        check("post-abort tick active", active_flat, 64'h0);
        check("post-abort pending", 64'(pending), 64'h0);
        check("post-abort commit_done", 64'(commit_done), 64'h0);
        check("post-abort shadow0", 64'(rd_data), 64'h0);

        // Three-channel instance: address 3 is out of range.
        w3_en = 1'b1; w3_addr = 2'd3; w3_data = 16'hFFFF;
        step();
        check("ch3 oob write dirty", 64'(d3_dirty), 64'h0);
        w3_addr = 2'd2; w3_data = 16'h2222;
        step();
        w3_en = 1'b0;
        check("ch3 in-range dirty", 64'(d3_dirty), 64'h4);
        r3_sel = 1'b0; r3_addr = 2'd3;
        step();
        check("ch3 oob read shadow", 64'(r3_data), 64'h0);
        r3_sel = 1'b1;
        step();
        check("ch3 oob read active", 64'(r3_data), 64'h0);
        r3_sel = 1'b0; r3_addr = 2'd2;
        step();
        check("ch3 read shadow2", 64'(r3_data), 64'h2222);
        c3_req = 1'b1;
        step();
        c3_req = 1'b0; t3_tick = 1'b1;
        step();
        t3_tick = 1'b0;
        check("ch3 commit active", 64'(a3_flat), 64'h2222_0000_0000);
        check("ch3 commit_done", 64'(c3_done), 64'h1);
        check("ch3 dirty cleared", 64'(d3_dirty), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coef_bank_shadow.md
Name: coef_bank_shadow

Overview:
- Parametrised, double-buffered coefficient register bank for the equalizer datapath; the multi-channel, multi-bit generation of the single enabled register.
- Control side writes per-band coefficients into a shadow bank.
- A commit request transfers all modified (dirty) shadow entries to the active bank atomically on the next audio sample tick, so filters never see a half-updated coefficient set.

Parameters:
- WIDTH, 16, bits per coefficient.
- CHANNELS, 4, number of coefficient entries (equalizer bands); 1 to 2**AW.
- AW, 2, address width of write/read ports.
- RESET_VAL, 0, value loaded into every shadow and active entry on reset (WIDTH bits).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  shadow write strobe.
- wr_addr  in  AW  shadow entry to write.
- wr_data  in  WIDTH  coefficient to write.
- commit_req  in  1  single-cycle request to commit dirty entries.
- sample_tick  in  1  single-cycle audio sample boundary strobe.
- rd_sel  in  1  readback bank select: 0 = shadow, 1 = active.
- rd_addr  in  AW  readback entry.
- rd_data  out  WIDTH  registered readback data.
- active_flat  out  CHANNELS*WIDTH  all active coefficients; entry i at bits [i*WIDTH +: WIDTH].
- dirty  out  CHANNELS  per-entry flag: shadow differs in history from active (written since last commit).
- pending  out  1  high while a commit is armed and waiting for sample_tick.
- commit_done  out  1  one-cycle pulse in the cycle after the commit edge.

Behaviour:
- Reset (async, active-high; clock clk):
  - All shadow and active entries = RESET_VAL.
  - dirty = 0, pending = 0, commit_done = 0, rd_data = 0, FSM = IDLE.
  - Reset asserted mid-PENDING aborts the commit; no active entry changes.
- Shadow write:
  - wr_en with wr_addr < CHANNELS: shadow[wr_addr] <= wr_data; dirty[wr_addr] <= 1.
  - wr_addr >= CHANNELS: write ignored, no flag change.
  - Writes are accepted in every state.
- FSM has two states:
  - IDLE:
    - commit_req with dirty != 0 -> PENDING; pending = 1 from the next cycle.
    - commit_req with dirty == 0 (including a write in the same cycle) -> ignored; stays IDLE; no commit_done.
    - sample_tick in IDLE has no effect.
    - commit_req and sample_tick in the same IDLE cycle -> PENDING; commit waits for the *next* tick.
  - PENDING:
    - On sample_tick edge, for every i with dirty[i] = 1: active[i] <= shadow[i] (value before this edge).
    - Then dirty[i] <= 0, pending <= 0, state -> IDLE; commit_done = 1 for exactly the following cycle.
    - Further commit_req in PENDING is ignored (already armed).
- Simultaneous write and commit edge:
  - The write lands in shadow but is NOT committed; the active entry takes the pre-write shadow value.
  - dirty[wr_addr] stays/becomes 1 after the edge.
- Active bank changes only on a commit edge or reset. Non-dirty entries are never rewritten.
- Readback:
  - rd_data <= (rd_sel ? active : shadow)[rd_addr], one-cycle latency, every cycle.
  - rd_addr >= CHANNELS returns 0.
  - Same-cycle write to the read entry: rd_data shows the old shadow value (read-before-write).
- active_flat is driven directly from the active registers (no added latency).
- No arithmetic; all values are stored and moved unmodified at WIDTH bits.

Test Plan:
- Reset, then read all entries with rd_sel = 0 and 1 -> every rd_data = 0, dirty = 4'b0000, pending = 0.
- Write ch1 = 16'h1234 and ch3 = 16'hABCD; pulse commit_req; wait 5 cycles; pulse sample_tick:
  - active_flat unchanged (all 0) until the tick edge, then ch1 = 1234, ch3 = ABCD.
  - dirty: 4'b1010 -> 0; commit_done pulses once.
- Commit_req with dirty = 0 -> pending stays 0, no commit_done, active unchanged after a later tick.
- Armed commit with ch2 dirty at 16'h0055; write ch2 = 16'h00AA in the same cycle as sample_tick:
  - active ch2 = 0055; shadow ch2 = 00AA; dirty = 4'b0100 afterwards.
- Assert reset while pending with ch0 dirty -> active ch0 stays RESET_VAL; pending = 0; a subsequent tick changes nothing.
- Write wr_addr = 3 with CHANNELS = 3 (override) -> no change; readback rd_addr = 3 returns 0.
